// File: rtl/apb_slave.sv
// apb_slave: APB responder with a word-addressed register bank and a fixed
// number of wait states per transfer.
// Optional feature macro: APB_SLAVE_PSLVERR_EN. When defined, accesses outside
// the bank (paddr >= DEPTH*4) or with paddr[1:0] != 0 complete with
// pslverr=1, reads return 0, and writes are dropped. When undefined, pslverr
// is tied to 0 and addresses alias modulo DEPTH*4.
module apb_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int         IW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic                  w_setup, w_done, w_abort, w_set_rdy;
  logic [IW-1:0]         w_idx, w_cur_idx;
  logic                  w_cur_wr, w_cur_ok;

  assign w_idx = paddr[2 +: IW];

  // Bus events seen on the current edge.
  assign w_setup = (r_state == IDLE)   &&  psel && !penable;
  assign w_abort = (r_state == ACCESS) && !psel;
  assign w_done  = (r_state == ACCESS) &&  psel && penable && r_pready;

  // pready rises when the wait counter hits zero; with no wait states that
  // is already the setup edge, so the live bus fields must be used there.
  assign w_set_rdy = (w_setup && (WAIT_LD == 4'd0)) ||
                     ((r_state == ACCESS) && psel && (r_cnt == 4'd1));
  assign w_cur_idx = w_setup ? w_idx  : r_idx;
  assign w_cur_wr  = w_setup ? pwrite : r_wr;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * 4);

  logic r_ok;
  logic r_slverr;
  logic w_ok;

  assign w_ok     = (paddr < LIMIT) && (paddr[1:0] == 2'b00);
  assign w_cur_ok = w_setup ? w_ok : r_ok;
  assign pslverr  = r_slverr;

  // Range verdict is frozen at setup along with the rest of the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ok <= 1'b0;
    else if (w_setup) r_ok <= w_ok;
  end

  // Error flag shadows pready: set with it, cleared with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_slverr <= 1'b0;
    else if (w_done || w_abort) r_slverr <= 1'b0;
    else if (w_set_rdy)         r_slverr <= !w_cur_ok;
  end
`else
  logic w_unused_addr;

  // Only the index bits matter; the rest of the address aliases.
  assign w_unused_addr = ^{paddr[ADDR_WIDTH-1:2+IW], paddr[1:0]};
  assign w_cur_ok      = 1'b1;
  assign pslverr       = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: setup enters ACCESS, completion or abort returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (psel && !penable) w_state_nxt = ACCESS;
      ACCESS:  if (!psel || (penable && r_pready)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture on the setup edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else if (w_setup) begin
      r_idx   <= w_idx;
      r_wr    <= pwrite;
      r_wdata <= pwdata;
    end
  end

  // Wait counter: load at setup, count down through the access phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_cnt <= 4'd0;
    else if (w_setup)                          r_cnt <= WAIT_LD;
    else if (w_abort)                          r_cnt <= 4'd0;
    else if (r_state == ACCESS && r_cnt != 0)  r_cnt <= r_cnt - 4'd1;
  end

  // Registered pready, high for exactly one cycle per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_pready <= 1'b0;
    else if (w_done || w_abort) r_pready <= 1'b0;
    else if (w_set_rdy)         r_pready <= 1'b1;
  end

  // Read data is sampled alongside pready and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_prdata <= '0;
    else if (w_set_rdy && !w_cur_wr)
      r_prdata <= w_cur_ok ? r_mem[w_cur_idx] : '0;
  end

  // Register bank: writes land only on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_done && r_wr && w_cur_ok) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign prdata = r_prdata;
  assign pready = r_pready;

endmodule
